// File: rtl/enc8to3_arbiter.sv
// Sequential 8-to-3 request encoder/arbiter with Valid/Ack handshake and optional grant timeout.
// Define ENC_RR_ARB_EN for round-robin selection; fixed priority (lowest code wins) otherwise.
module enc8to3_arbiter #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic       clock_i,
    input  logic       resetn_i,
    input  logic       en_i,
    input  logic [7:0] req_i,
    input  logic       ack_i,
    output logic [2:0] w_o,
    output logic [7:0] g_o,
    output logic       valid_o,
    output logic       timeout_o
);

    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      w_q, w_d;
    logic [7:0]      g_q, g_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [7:0] req_code;
    logic [2:0] win_code;
    logic       start_grant;
    logic       tmo_hit;

    // Requests re-indexed by code: code i is driven by req_i[7-i].
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            req_code[i] = req_i[7-i];
        end
    end

`ifdef ENC_RR_ARB_EN
    // Search upward from the code after the last grant, wrapping at 8.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        found    = 1'b0;
        idx      = '0;
        win_code = '0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k + 1);
            if (!found && req_code[idx]) begin
                win_code = idx;
                found    = 1'b1;
            end
        end
    end
`else
    // Descending scan so the lowest set code is the final assignment.
    always_comb begin
        win_code = '0;
        for (int k = 7; k >= 0; k--) begin
            if (req_code[k]) begin
                win_code = 3'(k);
            end
        end
    end
`endif

    assign start_grant = en_i && (|req_i);
    assign tmo_hit     = (TIMEOUT != 0) && (cnt_q == CntMax);

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= StIdle;
            w_q       <= '0;
            g_q       <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= 3'b111;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            g_q       <= g_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_grant) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (ack_i || tmo_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        w_d       = w_q;
        g_d       = g_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_grant) begin
                    w_d     = win_code;
                    g_d     = 8'b1000_0000 >> win_code;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    valid_d = 1'b0;
                    g_d     = '0;
                end
            end
            StGrant: begin
                // Ack takes precedence over a coincident timeout expiry.
                if (ack_i) begin
                    valid_d = 1'b0;
                    g_d     = '0;
                    ptr_d   = w_q;
                end else if (tmo_hit) begin
                    valid_d   = 1'b0;
                    g_d       = '0;
                    timeout_d = 1'b1;
                    ptr_d     = w_q;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                valid_d = 1'b0;
                g_d     = '0;
            end
        endcase
    end

    assign w_o       = w_q;
    assign g_o       = g_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

    a_grant_onehot: assert property (@(posedge clock_i) disable iff (!resetn_i)
        valid_q |-> (g_q == (8'b1000_0000 >> w_q)));
    a_grant_idle_zero: assert property (@(posedge clock_i) disable iff (!resetn_i)
        !valid_q |-> (g_q == 8'h00));

endmodule

// File: tb/tb_enc8to3_arbiter.sv
// Self-checking bench for enc8to3_arbiter: scoreboard of predicted grant codes plus per-scenario
// checks; a second instance with TIMEOUT=0 covers the no-timeout hold.
module tb_enc8to3_arbiter;

    localparam int unsigned TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, ack;
    logic [7:0] req;
    logic [2:0] w;
    logic [7:0] g;
    logic       valid, tmo;
    logic       en_z, ack_z;
    logic [7:0] req_z;
    logic [2:0] w_z;
    logic [7:0] g_z;
    logic       valid_z, tmo_z;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] exp_q[$];
    bit         m_grant;
    logic [2:0] m_w, m_ptr;
    int         m_cnt;

    always #5 clk = ~clk;

    enc8to3_arbiter #(.TIMEOUT(TMO)) dut (
        .clock_i  (clk),
        .resetn_i (rst_n),
        .en_i     (en),
        .req_i    (req),
        .ack_i    (ack),
        .w_o      (w),
        .g_o      (g),
        .valid_o  (valid),
        .timeout_o(tmo)
    );

    enc8to3_arbiter #(.TIMEOUT(0)) dut_z (
        .clock_i  (clk),
        .resetn_i (rst_n),
        .en_i     (en_z),
        .req_i    (req_z),
        .ack_i    (ack_z),
        .w_o      (w_z),
        .g_o      (g_z),
        .valid_o  (valid_z),
        .timeout_o(tmo_z)
    );

    function automatic logic [2:0] model_win(input logic [7:0] r, input logic [2:0] p);
`ifdef ENC_RR_ARB_EN
        for (int k = 1; k <= 8; k++) begin
            int c;
            c = (int'(p) + k) % 8;
            if (r[7-c]) return 3'(c);
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (r[i]) return 3'(7 - i);
        end
`endif
        return 3'd0;
    endfunction

    task automatic model_reset();
        m_grant = 1'b0;
        m_ptr   = 3'b111;
        m_cnt   = 0;
        m_w     = 3'b000;
        exp_q.delete();
    endtask

    // Advance the model on the current inputs, then step the clock and settle.
    task automatic tick();
        if (!m_grant) begin
            if (en && req != 8'h00) begin
                m_w = model_win(req, m_ptr);
                exp_q.push_back(m_w);
                m_grant = 1'b1;
                m_cnt   = 0;
            end
        end else if (ack) begin
            m_ptr   = m_w;
            m_grant = 1'b0;
        end else if (m_cnt == int'(TMO) - 1) begin
            m_ptr   = m_w;
            m_grant = 1'b0;
        end else begin
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0; req = '0; ack = 1'b0;
        en_z = 1'b0; req_z = '0; ack_z = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if ({valid, g, w, tmo, valid_z, tmo_z} !== 14'd0)
            $display("FAIL reset_state: got valid=%b g=%b w=%b tmo=%b vz=%b, want all 0",
                     valid, g, w, tmo, valid_z);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({valid, g, w, tmo} !== 13'd0)
                $display("FAIL idle_no_req[%0d]: got valid=%b g=%b w=%b tmo=%b, want 0",
                         i, valid, g, w, tmo);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        logic [2:0] e;
        req = 8'b0010_0000;
        en  = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b1) $display("FAIL single_valid: got %b want 1", valid);
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL single_sb: grant seen, none predicted");
        else begin
            e = exp_q.pop_front();
            if (w !== e || g !== (8'h80 >> e))
                $display("FAIL single_sb: got w=%b g=%b want w=%b", w, g, e);
            else n_pass++;
        end
        n_checks++;
        if (w !== 3'b010 || g !== 8'b0010_0000)
            $display("FAIL single_code: got w=%b g=%b want 010/00100000", w, g);
        else n_pass++;
        req = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (valid !== 1'b1 || w !== 3'b010 || g !== 8'b0010_0000)
                $display("FAIL single_hold[%0d]: got v=%b w=%b g=%b", i, valid, w, g);
            else n_pass++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || g !== 8'h00 || w !== 3'b010 || tmo !== 1'b0)
            $display("FAIL single_ack: got v=%b g=%b w=%b t=%b want 0/0/010/0", valid, g, w, tmo);
        else n_pass++;
        tick();
        n_checks++;
        if (valid !== 1'b0) $display("FAIL single_idle: got valid=%b want 0", valid);
        else n_pass++;
    endtask

    task automatic test_priority();
        logic [2:0] e;
        req = 8'b0100_0001;
        en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ack = 1'b0;
            tick();
            n_checks++;
            if (valid !== 1'b1 || exp_q.size() == 0)
                $display("FAIL prio_grant[%0d]: got valid=%b queued=%0d", i, valid, exp_q.size());
            else begin
                e = exp_q.pop_front();
                if (w !== e || g !== (8'h80 >> e))
                    $display("FAIL prio_grant[%0d]: got w=%b g=%b want w=%b", i, w, g, e);
                else n_pass++;
            end
`ifndef ENC_RR_ARB_EN
            n_checks++;
            if (w !== 3'b001 || g !== 8'b0100_0000)
                $display("FAIL prio_fixed[%0d]: got w=%b g=%b want 001/01000000", i, w, g);
            else n_pass++;
`endif
            ack = 1'b1;
            tick();
            n_checks++;
            if (valid !== 1'b0 || g !== 8'h00)
                $display("FAIL prio_gap[%0d]: got valid=%b g=%b want 0", i, valid, g);
            else n_pass++;
        end
        ack = 1'b0;
        en  = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] e, prev;
        prev = 3'b000;
        req  = 8'hFF;
        en   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ack = 1'b0;
            tick();
            n_checks++;
            if (valid !== 1'b1 || exp_q.size() == 0)
                $display("FAIL b2b_grant[%0d]: got valid=%b queued=%0d", i, valid, exp_q.size());
            else begin
                e = exp_q.pop_front();
                if (w !== e || g !== (8'h80 >> e))
                    $display("FAIL b2b_grant[%0d]: got w=%b g=%b want w=%b", i, w, g, e);
                else n_pass++;
            end
`ifdef ENC_RR_ARB_EN
            if (i > 0) begin
                n_checks++;
                if (w !== prev + 3'd1)
                    $display("FAIL b2b_rr_seq[%0d]: got w=%b want %b", i, w, prev + 3'd1);
                else n_pass++;
            end
`else
            n_checks++;
            if (w !== 3'b000) $display("FAIL b2b_fixed[%0d]: got w=%b want 000", i, w);
            else n_pass++;
`endif
            prev = w;
            ack  = 1'b1;
            tick();
            n_checks++;
            if (valid !== 1'b0) $display("FAIL b2b_gap[%0d]: got valid=%b want 0", i, valid);
            else n_pass++;
        end
        ack = 1'b0;
        en  = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        logic [2:0] e;
        req = 8'b0000_0001;
        en  = 1'b1;
        ack = 1'b0;
        tick();
        en = 1'b0;
        n_checks++;
        if (valid !== 1'b1 || exp_q.size() == 0)
            $display("FAIL tmo_grant: got valid=%b queued=%0d", valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if (w !== e || w !== 3'b111 || g !== 8'b0000_0001)
                $display("FAIL tmo_grant: got w=%b g=%b want w=111 (model %b)", w, g, e);
            else n_pass++;
        end
        for (int i = 1; i < int'(TMO); i++) begin
            tick();
            n_checks++;
            if (valid !== 1'b1 || tmo !== 1'b0)
                $display("FAIL tmo_hold[%0d]: got valid=%b tmo=%b want 1/0", i, valid, tmo);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (valid !== 1'b0 || tmo !== 1'b1 || g !== 8'h00)
            $display("FAIL tmo_expire: got valid=%b tmo=%b g=%b want 0/1/0", valid, tmo, g);
        else n_pass++;
        tick();
        n_checks++;
        if (tmo !== 1'b0 || valid !== 1'b0)
            $display("FAIL tmo_pulse: got tmo=%b valid=%b want 0/0", tmo, valid);
        else n_pass++;
    endtask

    task automatic test_no_timeout();
        int held, tmo_seen;
        en = 1'b0; req = 8'h00; ack = 1'b0;
        req_z = 8'b0000_0001;
        en_z  = 1'b1;
        ack_z = 1'b0;
        @(posedge clk);
        #1;
        en_z = 1'b0;
        n_checks++;
        if (valid_z !== 1'b1 || w_z !== 3'b111 || g_z !== 8'b0000_0001)
            $display("FAIL notmo_grant: got v=%b w=%b g=%b want 1/111/00000001", valid_z, w_z, g_z);
        else n_pass++;
        held = 0;
        tmo_seen = 0;
        for (int i = 0; i < 110; i++) begin
            @(posedge clk);
            #1;
            if (valid_z === 1'b1) held++;
            if (tmo_z !== 1'b0) tmo_seen++;
        end
        n_checks++;
        if (held != 110 || tmo_seen != 0)
            $display("FAIL notmo_hold: got held=%0d tmo_cycles=%0d want 110/0", held, tmo_seen);
        else n_pass++;
        ack_z = 1'b1;
        @(posedge clk);
        #1;
        ack_z = 1'b0;
        req_z = 8'h00;
        n_checks++;
        if (valid_z !== 1'b0) $display("FAIL notmo_ack: got valid=%b want 0", valid_z);
        else n_pass++;
    endtask

    task automatic test_en_low();
        en  = 1'b0;
        req = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (valid !== 1'b0 || g !== 8'h00)
                $display("FAIL en_low[%0d]: got valid=%b g=%b want 0", i, valid, g);
            else n_pass++;
        end
    endtask

    task automatic test_ack_timeout_coincide();
        logic [2:0] e;
        req = 8'hFF;
        en  = 1'b1;
        ack = 1'b0;
        tick();
        en = 1'b0;
        n_checks++;
        if (valid !== 1'b1 || exp_q.size() == 0)
            $display("FAIL coinc_grant: got valid=%b queued=%0d", valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if (w !== e) $display("FAIL coinc_grant: got w=%b want %b", w, e);
            else n_pass++;
        end
        for (int i = 1; i < int'(TMO); i++) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || tmo !== 1'b0)
            $display("FAIL coinc_ack_wins: got valid=%b tmo=%b want 0/0", valid, tmo);
        else n_pass++;
        tick();
        n_checks++;
        if (tmo !== 1'b0) $display("FAIL coinc_no_pulse: got tmo=%b want 0", tmo);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [2:0] e;
        req = 8'hFF;
        en  = 1'b1;
        ack = 1'b0;
        tick();
        n_checks++;
        if (valid !== 1'b1 || exp_q.size() == 0)
            $display("FAIL rstmid_grant: got valid=%b queued=%0d", valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if (w !== e) $display("FAIL rstmid_grant: got w=%b want %b", w, e);
            else n_pass++;
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (valid !== 1'b0 || g !== 8'h00 || tmo !== 1'b0)
            $display("FAIL rstmid_async: got valid=%b g=%b tmo=%b want 0", valid, g, tmo);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({valid, g, w, tmo} !== 13'd0)
            $display("FAIL rstmid_held: got v=%b g=%b w=%b t=%b want 0", valid, g, w, tmo);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b1 || exp_q.size() == 0)
            $display("FAIL rstmid_regrant: got valid=%b queued=%0d", valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if (w !== e || w !== 3'b000 || g !== 8'b1000_0000)
                $display("FAIL rstmid_regrant: got w=%b g=%b want 000/10000000", w, g);
            else n_pass++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        en  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_timeout();
        test_no_timeout();
        test_en_low();
        test_ack_timeout_coincide();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded 200000 time units, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
